// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module      : f1_reaction_timer
//  Description : Driver reaction timer for an F1 start sequence. Measures the
//                ms between lights-out and the driver's button press, in
//                binary and 4-digit BCD. Flags jump starts and timeouts, and
//                keeps a best-time record.
//  Revision    : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int MAX_MS      = 9999,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        tick,
    input  logic        lights_on,
    input  logic        lights_out,
    input  logic        button,
    output logic        busy,
    output logic        rt_valid,
    output logic [13:0] rt_ms,
    output logic [15:0] rt_bcd,
    output logic        jump_start,
    output logic        timeout,
    output logic [13:0] best_ms,
    output logic [15:0] best_bcd
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_ARMED    = 2'd1;
    localparam logic [1:0]  c_TIMING   = 2'd2;
    localparam logic [1:0]  c_RESULT   = 2'd3;
    localparam logic [13:0] c_MAX      = 14'(MAX_MS);
    localparam logic [13:0] c_BEST_RST = 14'd9999;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_btn_prev;
    logic [1:0]             r_state;
    logic                   r_lights_on_d;
    logic [13:0]            r_cnt;
    logic [15:0]            r_bcd_cnt;
    logic                   r_busy;
    logic                   r_rt_valid;
    logic [13:0]            r_rt_ms;
    logic [15:0]            r_rt_bcd;
    logic                   r_jump_start;
    logic                   r_timeout;
    logic [13:0]            r_best_ms;
    logic [15:0]            r_best_bcd;

    logic                   w_press;
    logic                   w_lights_rise;

    // Increment a 4-digit BCD value, each digit rolling 9 -> 0 with carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Button synchronizer chain followed by the edge-detect history flop.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sync     <= '0;
            r_btn_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], button};
            r_btn_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_press       = r_sync[SYNC_STAGES-1] & ~r_btn_prev;
    assign w_lights_rise = lights_on & ~r_lights_on_d;

    // Start/measure/result state machine with all outputs registered.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_lights_on_d <= 1'b0;
            r_cnt         <= '0;
            r_bcd_cnt     <= '0;
            r_busy        <= 1'b0;
            r_rt_valid    <= 1'b0;
            r_rt_ms       <= '0;
            r_rt_bcd      <= '0;
            r_jump_start  <= 1'b0;
            r_timeout     <= 1'b0;
            r_best_ms     <= c_BEST_RST;
            r_best_bcd    <= 16'h9999;
        end else begin
            r_lights_on_d <= lights_on;
            r_rt_valid    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (lights_on) begin
                        r_state <= c_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                c_ARMED: begin
                    // A press here is a jump start, even if the lights go
                    // out in the very same cycle.
                    if (w_press) begin
                        r_state      <= c_RESULT;
                        r_busy       <= 1'b0;
                        r_jump_start <= 1'b1;
                    end else if (lights_out) begin
                        r_state   <= c_TIMING;
                        r_cnt     <= '0;
                        r_bcd_cnt <= '0;
                    end else if (!lights_on) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                c_TIMING: begin
                    // Press beats a coincident tick, so that tick is dropped.
                    if (w_press) begin
                        r_state    <= c_RESULT;
                        r_busy     <= 1'b0;
                        r_rt_valid <= 1'b1;
                        r_rt_ms    <= r_cnt;
                        r_rt_bcd   <= r_bcd_cnt;
                        if (r_cnt < r_best_ms) begin
                            r_best_ms  <= r_cnt;
                            r_best_bcd <= r_bcd_cnt;
                        end
                    end else if (tick) begin
                        if (r_cnt == c_MAX) begin
                            r_state   <= c_RESULT;
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_cnt     <= r_cnt + 14'd1;
                            r_bcd_cnt <= bcd_inc(r_bcd_cnt);
                        end
                    end
                end
                default: begin
                    // Re-arm only on a fresh rising edge of lights_on.
                    if (w_lights_rise) begin
                        r_state      <= c_ARMED;
                        r_busy       <= 1'b1;
                        r_jump_start <= 1'b0;
                        r_timeout    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign rt_valid   = r_rt_valid;
    assign rt_ms      = r_rt_ms;
    assign rt_bcd     = r_rt_bcd;
    assign jump_start = r_jump_start;
    assign timeout    = r_timeout;
    assign best_ms    = r_best_ms;
    assign best_bcd   = r_best_bcd;

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f1_reaction_timer
//  Description : Directed self-checking bench for f1_reaction_timer. A second
//                instance with MAX_MS=20 shares the stimulus for timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    logic        sysclk = 1'b0;
    logic        rst, tick, lights_on, lights_out, button;
    logic        busy, rt_valid, jump_start, timeout;
    logic [13:0] rt_ms, best_ms;
    logic [15:0] rt_bcd, best_bcd;
    logic        busy_t, rt_valid_t, jump_start_t, timeout_t;
    logic [13:0] rt_ms_t, best_ms_t;
    logic [15:0] rt_bcd_t, best_bcd_t;

    int total = 0;
    int bad   = 0;
    int n_valid   = 0;
    int n_valid_t = 0;
    int v0, vt0;

    f1_reaction_timer dut (
        .sysclk(sysclk), .rst(rst), .tick(tick), .lights_on(lights_on),
        .lights_out(lights_out), .button(button), .busy(busy),
        .rt_valid(rt_valid), .rt_ms(rt_ms), .rt_bcd(rt_bcd),
        .jump_start(jump_start), .timeout(timeout), .best_ms(best_ms),
        .best_bcd(best_bcd)
    );

    f1_reaction_timer #(.MAX_MS(20)) dut_t (
        .sysclk(sysclk), .rst(rst), .tick(tick), .lights_on(lights_on),
        .lights_out(lights_out), .button(button), .busy(busy_t),
        .rt_valid(rt_valid_t), .rt_ms(rt_ms_t), .rt_bcd(rt_bcd_t),
        .jump_start(jump_start_t), .timeout(timeout_t), .best_ms(best_ms_t),
        .best_bcd(best_bcd_t)
    );

    always #5 sysclk = ~sysclk;

    // Count rt_valid pulses away from the active edge.
    always @(negedge sysclk) begin
        if (rt_valid)   n_valid++;
        if (rt_valid_t) n_valid_t++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic press();
        button = 1'b1; step(4);
        button = 1'b0; step(3);
    endtask

    // Rising lights_on, then lights out: ends with the timer running at 0.
    task automatic arm_and_go();
        lights_on = 1'b1; step(2);
        lights_on = 1'b0; lights_out = 1'b1; step();
        lights_out = 1'b0;
    endtask

    task automatic run(input int ms);
        arm_and_go();
        ticks(ms);
        press();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; lights_on = 1'b0; lights_out = 1'b0; button = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_rt_valid", 32'(rt_valid),   32'd0);
        chk("rst_rt_ms",    32'(rt_ms),      32'd0);
        chk("rst_rt_bcd",   32'(rt_bcd),     32'h0);
        chk("rst_jump",     32'(jump_start), 32'd0);
        chk("rst_timeout",  32'(timeout),    32'd0);
        chk("rst_best_ms",  32'(best_ms),    32'd9999);
        chk("rst_best_bcd", 32'(best_bcd),   32'h9999);

        // Normal reaction of 237 ms
        v0 = n_valid;
        arm_and_go();
        ticks(237);
        chk("run_busy", 32'(busy), 32'd1);
        press();
        chk("n237_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("n237_rt_ms",     32'(rt_ms),    32'd237);
        chk("n237_rt_bcd",    32'(rt_bcd),   32'h0237);
        chk("n237_best_ms",   32'(best_ms),  32'd237);
        chk("n237_best_bcd",  32'(best_bcd), 32'h0237);
        chk("n237_busy",      32'(busy),     32'd0);

        // Jump start: press in ARMED, then ticks, then lights_out (ignored)
        v0 = n_valid;
        lights_on = 1'b1; step(2);
        chk("arm_busy", 32'(busy), 32'd1);
        press();
        ticks(5);
        lights_on = 1'b0; lights_out = 1'b1; step();
        lights_out = 1'b0; step(2);
        chk("js_flag",      32'(jump_start),     32'd1);
        chk("js_no_valid",  32'(n_valid - v0),   32'd0);
        chk("js_rt_ms",     32'(rt_ms),          32'd237);
        chk("js_busy",      32'(busy),           32'd0);
        lights_on = 1'b1; step(2);
        chk("js_cleared",   32'(jump_start),     32'd0);
        chk("js_rearmed",   32'(busy),           32'd1);

        // Press and lights_out in the same cycle: press wins
        button = 1'b1; step(2);
        lights_on = 1'b0; lights_out = 1'b1; step();
        lights_out = 1'b0; step(2);
        button = 1'b0; step(2);
        chk("sim_lo_jump", 32'(jump_start), 32'd1);
        chk("sim_lo_busy", 32'(busy),       32'd0);

        // Press and tick in the same cycle at count 99
        v0 = n_valid;
        lights_on = 1'b1; step(2);
        lights_on = 1'b0; lights_out = 1'b1; step();
        lights_out = 1'b0;
        ticks(99);
        button = 1'b1; step(2);
        tick = 1'b1; step();
        tick = 1'b0; step(2);
        button = 1'b0; step(3);
        chk("sim_tk_valid",    32'(n_valid - v0), 32'd1);
        chk("sim_tk_rt_ms",    32'(rt_ms),        32'd99);
        chk("sim_tk_rt_bcd",   32'(rt_bcd),       32'h0099);
        chk("sim_tk_best_ms",  32'(best_ms),      32'd99);
        chk("sim_tk_best_bcd", 32'(best_bcd),     32'h0099);

        // Best tracking: 300, 180, 250, then an equal 180
        do_reset();
        run(300);
        chk("best1_ms", 32'(best_ms), 32'd300);
        run(180);
        chk("best2_ms", 32'(best_ms), 32'd180);
        run(250);
        chk("best3_ms",  32'(best_ms),  32'd180);
        chk("best3_bcd", 32'(best_bcd), 32'h0180);
        chk("best3_rt",  32'(rt_bcd),   32'h0250);
        run(180);
        chk("best4_ms",  32'(best_ms),  32'd180);
        chk("best4_bcd", 32'(best_bcd), 32'h0180);

        // Timeout on the MAX_MS=20 instance
        do_reset();
        vt0 = n_valid_t;
        arm_and_go();
        ticks(20);
        chk("to_before",      32'(timeout_t), 32'd0);
        chk("to_busy_before", 32'(busy_t),    32'd1);
        ticks(1);
        chk("to_flag",        32'(timeout_t), 32'd1);
        chk("to_busy_after",  32'(busy_t),    32'd0);
        press();
        chk("to_no_valid",    32'(n_valid_t - vt0), 32'd0);
        chk("to_rt_ms",       32'(rt_ms_t),   32'd0);
        chk("to_still",       32'(timeout_t), 32'd1);
        chk("to_best",        32'(best_ms_t), 32'd9999);

        // Reset in the middle of TIMING at count 150
        do_reset();
        run(100);
        arm_and_go();
        ticks(150);
        chk("mr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("mr_busy",     32'(busy),     32'd0);
        chk("mr_rt_ms",    32'(rt_ms),    32'd0);
        chk("mr_rt_bcd",   32'(rt_bcd),   32'h0);
        chk("mr_best_ms",  32'(best_ms),  32'd9999);
        chk("mr_best_bcd", 32'(best_bcd), 32'h9999);
        v0 = n_valid;
        press();
        chk("mr_no_valid", 32'(n_valid - v0), 32'd0);
        chk("mr_rt_after", 32'(rt_ms),        32'd0);
        chk("mr_idle",     32'(busy),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Measures driver reaction time at the end of an F1 start sequence. It consumes the armed/lights-out events produced by the start-light controller, and a driver push-button. It reports the reaction time in milliseconds as binary and 4-digit BCD, and flags jump starts and timeouts. It also keeps a best-time record for the 7-segment display path.

## Interface

Parameters:
- MAX_MS, 9999: timeout limit in ms (≤ 9999).
- SYNC_STAGES, 2: button synchronizer depth (≥ 2).

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 1 kHz strobe (1 ms base).
- lights_on  in  1  high while any start light is lit or the random delay is running.
- lights_out  in  1  one-cycle pulse when the lights go out (end of delay).
- button  in  1  raw, asynchronous driver button, active-high.
- busy  out  1  high in ARMED or TIMING.
- rt_valid  out  1  one-cycle pulse when a valid reaction time is captured.
- rt_ms  out  14  last reaction time, binary ms.
- rt_bcd  out  16  last reaction time, 4 BCD digits, thousands in [15:12].
- jump_start  out  1  sticky flag: press before lights_out.
- timeout  out  1  sticky flag: no press within MAX_MS.
- best_ms  out  14  best valid time since reset.
- best_bcd  out  16  best_ms in BCD.

## Operation

- Button path:
  - SYNC_STAGES flops feed one edge-detect flop.
  - press = sync_out & ~prev, a one-cycle pulse per rising edge.
  - No debounce; the FSM ignores presses outside ARMED/TIMING.
- FSM states: IDLE, ARMED, TIMING, RESULT.
  - IDLE: lights_on=1 → ARMED.
  - ARMED: press → RESULT with jump_start=1. Otherwise lights_out → TIMING, with the ms counter and BCD counter cleared to 0. If press and lights_out occur in the same cycle, press wins (jump start).
  - TIMING:
    - Each tick increments the binary counter by 1 and the BCD counter by 1; BCD digits cascade 9→0 with carry.
    - press → RESULT. rt_ms/rt_bcd load the counter values, rt_valid pulses, and best is updated if rt_ms < best_ms (strictly less).
    - If press and tick occur in the same cycle, press wins and that tick is not counted.
    - If the counter equals MAX_MS and a tick arrives: → RESULT with timeout=1, rt_ms/rt_bcd unchanged, no rt_valid pulse.
  - RESULT:
    - Holds outputs and flags.
    - A rising edge of lights_on (registered compare) → ARMED. This clears jump_start and timeout; rt_ms/rt_bcd are kept.
    - lights_on still high on entry to RESULT does not re-arm; a new rising edge is required.
- lights_out outside ARMED is ignored. lights_on falling in ARMED without lights_out (aborted sequence) → IDLE, flags untouched.
- Counters never wrap; MAX_MS bounds them to 9999, which fits in 14 bits.
- best_bcd is updated in the same cycle as best_ms, copied from the BCD counter.

## Timing

- Reset values:
  - FSM: IDLE.
  - busy=0, rt_valid=0, rt_ms=0, rt_bcd=0, jump_start=0, timeout=0.
  - best_ms=9999, best_bcd=16'h9999.
  - Synchronizer and edge flop: 0.
- Button latency: press pulses SYNC_STAGES+1 cycles after button rises, given setup is met.
- rt_valid, rt_ms, rt_bcd and best update on the edge after the cycle in which press is high in TIMING.
- rt_ms equals the number of tick pulses strictly between the lights_out cycle and the press cycle, exclusive at both ends.
- busy is registered and tracks the state with no extra cycle.
- rst mid-operation returns all state and outputs, including best, to reset values on the next edge.

## Test plan

- Normal reaction: lights_on=1, then a lights_out pulse, 237 ticks, then a button press → rt_valid pulses once; rt_ms=237, rt_bcd=16'h0237, best_ms=237, best_bcd=16'h0237, busy falls.
- Jump start: press in ARMED, 5 ticks before lights_out → jump_start=1, no rt_valid, rt_ms unchanged. A later lights_out is ignored until a new lights_on rise, which clears jump_start.
- Timeout with MAX_MS=20: lights_out then 21 ticks with no press → timeout=1 on the 21st tick, no rt_valid. A press afterwards is ignored.
- Best tracking: three runs of 300, 180 and 250 ms → best_ms sequence 300, 180, 180; best_bcd=16'h0180. An equal time does not update best.
- Simultaneity:
  - press and lights_out in the same cycle → jump_start.
  - In TIMING at count 99, press and tick in the same cycle → rt_ms=99, rt_bcd=16'h0099.
- Reset mid-TIMING at count 150 → next cycle all outputs at reset values; a subsequent press does nothing.
